// File: rtl/bitcount_datapath.sv
// Bit-counting datapath: operand shift register, set-bit counter,
// result latch and two-digit active-low seven-segment display.
module bitcount_datapath #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_data,
  input  logic             r_shift,
  input  logic             inc_counter,
  input  logic             done,
  output logic             A_eq_0,
  output logic             a0,
  output logic [CW-1:0]    result,
  output logic             result_valid,
  output logic             overflow,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1
);

  localparam logic [CW-1:0] MAX = CW'(WIDTH);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd <= '0;
    end else if (load_data) begin
      opnd <= data_in;
    end else if (r_shift) begin
      opnd <= opnd >> 1;
    end
  end

  // Saturate at WIDTH; an extra increment only raises the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (load_data) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc_counter) begin
      if (count < MAX) begin
        count <= count + CW'(1);
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (load_data) begin
      result_valid <= 1'b0;
    end else if (done && !result_valid) begin
      result       <= count;
      result_valid <= 1'b1;
    end
  end

  assign A_eq_0 = (opnd == '0);
  assign a0     = opnd[0];

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    s = BLANK;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  logic [31:0] rv;

  always_comb begin
    rv   = 32'(result);
    HEX0 = BLANK;
    HEX1 = BLANK;
    if (result_valid) begin
      HEX0 = seg(4'(rv % 32'd10));
      if (rv >= 32'd10) begin
        HEX1 = seg(4'(rv / 32'd10));
      end
    end
  end

endmodule

// File: tb/tb_bitcount_datapath.sv
// Scoreboard bench for bitcount_datapath: 8-bit and 12-bit instances,
// expected latched results queued at stimulus, checked by monitors.
module tb_bitcount_datapath;

  typedef struct {
    int         res;
    logic [6:0] h0;
    logic [6:0] h1;
    logic       ovf;
  } exp_t;

  localparam logic [6:0] BL = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  din8 = '0;
  logic        ld8 = 0, sh8 = 0, inc8 = 0, dn8 = 0;
  logic        z8, b8, rv8, of8;
  logic [3:0]  res8;
  logic [6:0]  h0_8, h1_8;

  logic [11:0] din12 = '0;
  logic        ld12 = 0, sh12 = 0, inc12 = 0, dn12 = 0;
  logic        z12, b12, rv12, of12;
  logic [3:0]  res12;
  logic [6:0]  h0_12, h1_12;

  bitcount_datapath #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .data_in(din8),
    .load_data(ld8), .r_shift(sh8), .inc_counter(inc8), .done(dn8),
    .A_eq_0(z8), .a0(b8), .result(res8), .result_valid(rv8),
    .overflow(of8), .HEX0(h0_8), .HEX1(h1_8)
  );

  bitcount_datapath #(.WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .data_in(din12),
    .load_data(ld12), .r_shift(sh12), .inc_counter(inc12), .done(dn12),
    .A_eq_0(z12), .a0(b12), .result(res12), .result_valid(rv12),
    .overflow(of12), .HEX0(h0_12), .HEX1(h1_12)
  );

  int errors = 0;
  int checks = 0;
  exp_t q8[$];
  exp_t q12[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic pv8 = 0, pv12 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rv8 && !pv8) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("sb8_result", int'(res8), e.res);
        chk("sb8_hex0", int'(h0_8), int'(e.h0));
        chk("sb8_hex1", int'(h1_8), int'(e.h1));
        chk("sb8_ovf", int'(of8), int'(e.ovf));
      end
    end
    pv8 = rv8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rv12 && !pv12) begin
      if (q12.size() == 0) begin
        chk("unexpected_out12", 1, 0);
      end else begin
        e = q12.pop_front();
        chk("sb12_result", int'(res12), e.res);
        chk("sb12_hex0", int'(h0_12), int'(e.h0));
        chk("sb12_hex1", int'(h1_12), int'(e.h1));
        chk("sb12_ovf", int'(of12), int'(e.ovf));
      end
    end
    pv12 = rv12;
  end

  task automatic run8(output int shifts);
    int guard;
    shifts = 0;
    guard = 0;
    while (!z8 && guard < 40) begin
      sh8 = 1;
      inc8 = b8;
      tick();
      shifts++;
      guard++;
    end
    sh8 = 0;
    inc8 = 0;
    if (guard >= 40) chk("run8_timeout", 1, 0);
  endtask

  task automatic run12(output int shifts);
    int guard;
    shifts = 0;
    guard = 0;
    while (!z12 && guard < 40) begin
      sh12 = 1;
      inc12 = b12;
      tick();
      shifts++;
      guard++;
    end
    sh12 = 0;
    inc12 = 0;
    if (guard >= 40) chk("run12_timeout", 1, 0);
  endtask

  task automatic done8();
    dn8 = 1;
    tick();
    dn8 = 0;
  endtask

  initial begin
    int n;
    tick();
    tick();
    reset = 0;
    chk("rst_aeq0", int'(z8), 1);
    chk("rst_a0", int'(b8), 0);
    chk("rst_result", int'(res8), 0);
    chk("rst_valid", int'(rv8), 0);
    chk("rst_ovf", int'(of8), 0);
    chk("rst_hex0", int'(h0_8), int'(BL));
    chk("rst_hex1", int'(h1_8), int'(BL));

    // 12-bit all-ones: two-digit display
    din12 = 12'hFFF;
    ld12 = 1;
    tick();
    ld12 = 0;
    run12(n);
    chk("w12_shifts", n, 12);
    q12.push_back('{12, 7'b0100100, 7'b1111001, 1'b0});
    dn12 = 1;
    tick();
    dn12 = 0;
    chk("w12_valid", int'(rv12), 1);

    // 8'b1011_0010: four set bits, eight shifts
    din8 = 8'b1011_0010;
    ld8 = 1;
    tick();
    ld8 = 0;
    chk("t1_loaded_nz", int'(z8), 0);
    run8(n);
    chk("t1_shifts", n, 8);
    chk("t1_valid_pre", int'(rv8), 0);
    q8.push_back('{4, 7'b0011001, BL, 1'b0});
    done8();
    chk("t1_valid_lat", int'(rv8), 1);
    chk("t1_result", int'(res8), 4);

    // no relatch while valid
    inc8 = 1;
    tick();
    inc8 = 0;
    done8();
    chk("relatch_hold", int'(res8), 4);

    // load beats shift, inc and done
    din8 = 8'h81;
    ld8 = 1; sh8 = 1; inc8 = 1; dn8 = 1;
    tick();
    ld8 = 0; sh8 = 0; inc8 = 0; dn8 = 0;
    chk("prio_valid", int'(rv8), 0);
    chk("prio_result_hold", int'(res8), 4);
    chk("prio_a0", int'(b8), 1);
    chk("prio_aeq0", int'(z8), 0);
    sh8 = 1;
    tick();
    sh8 = 0;
    chk("prio_shift_a0", int'(b8), 0);
    chk("prio_shift_aeq0", int'(z8), 0);
    q8.push_back('{0, 7'b1000000, BL, 1'b0});
    done8();

    // zero operand
    din8 = 8'h00;
    ld8 = 1;
    tick();
    ld8 = 0;
    chk("zero_aeq0", int'(z8), 1);
    chk("zero_valid", int'(rv8), 0);
    q8.push_back('{0, 7'b1000000, BL, 1'b0});
    done8();

    // saturation and sticky overflow
    din8 = 8'hFF;
    ld8 = 1;
    tick();
    ld8 = 0;
    inc8 = 1;
    repeat (8) tick();
    chk("ovf_at_max", int'(of8), 0);
    tick();
    inc8 = 0;
    chk("ovf_set", int'(of8), 1);
    q8.push_back('{8, 7'b0000000, BL, 1'b1});
    done8();
    tick();
    chk("ovf_sticky", int'(of8), 1);

    // async reset mid-clock with a latched result pending
    #2;
    reset = 1;
    #1;
    chk("mid_rst_aeq0", int'(z8), 1);
    chk("mid_rst_result", int'(res8), 0);
    chk("mid_rst_valid", int'(rv8), 0);
    chk("mid_rst_ovf", int'(of8), 0);
    chk("mid_rst_hex0", int'(h0_8), int'(BL));
    chk("mid_rst_hex1", int'(h1_8), int'(BL));
    tick();
    reset = 0;

    // load clears overflow
    ld8 = 1;
    tick();
    ld8 = 0;
    inc8 = 1;
    repeat (9) tick();
    inc8 = 0;
    chk("ovf2_set", int'(of8), 1);
    ld8 = 1;
    tick();
    ld8 = 0;
    chk("ovf2_clear", int'(of8), 0);

    tick();
    tick();
    chk("q8_drained", q8.size(), 0);
    chk("q12_drained", q12.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
